trigger_hit_sequencer: RTL and testbench
========================================

# trigger_hit_sequencer

Sequential stage directly downstream of the debug-trigger comparator. Consumes the per-trigger, per-slot `Match` matrix, applies enable, slot-valid, debug-mode and chain qualification, and records sticky hit status. It then issues one prioritised trigger-action request to the core over a valid/ready handshake. Sits between the comparator and the core's exception / debug-entry logic.

## Interface
- `num_triggers`, 4: number of triggers; must match the comparator.
- `num_slots`, 4: number of commit slots; must match the comparator. Slot 0 is the oldest.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `match_in` in [num_triggers][num_slots] x 1: comparator `Match` outputs.
- `slot_valid` in [num_slots]: slot holds a committing instruction.
- `trig_enable` in [num_triggers]: trigger armed.
- `trig_chain` in [num_triggers]: trigger i chains to i+1. Bit num_triggers-1 is ignored and treated as 0.
- `trig_action` in [num_triggers]: 0 = breakpoint exception, 1 = enter debug mode.
- `debug_mode` in 1: core is in debug mode; all triggers are suppressed.
- `hit_clr` in [num_triggers]: CSR write clearing the matching sticky hit bit.
- `req_valid` out 1: action request pending.
- `req_ready` in 1: core accepts the request.
- `req_action` out 1: action of the request.
- `req_slot` out $clog2(num_slots): slot that fired.
- `req_trigger` out $clog2(num_triggers): first trigger of the firing chain group.
- `hit` out [num_triggers]: sticky hit bits.
- `busy` out 1: state is not IDLE.

## Operation
- **Stage 1 register `q[i][j]`:**
  - Loads `match_in & slot_valid[j] & trig_enable[i] & !debug_mode`.
  - Loads all-zero instead when state ≠ IDLE or when stage 2 fires this cycle.
- **Chain groups:** maximal runs i..k with `trig_chain[i..k-1]=1` and `trig_chain[k]=0`. A group fires in slot j iff `q[m][j]=1` for every member m.
- **Selection:**
  - Selected slot = lowest j containing any fired group.
  - `req_trigger` = lowest group-start index that fired in that slot.
  - `req_action` = 1 if any fired group in the selected slot has `trig_action` of its last member = 1; otherwise 0.
- **Hit bits:**
  - Every member of every fired group in the selected slot sets its `hit` bit.
  - Groups that fire only in younger slots are dropped and do not set hits.
  - If set and `hit_clr` coincide on the same bit, set wins.
- **FSM:**
  - **IDLE:** on fire → PEND; latch `req_action`, `req_slot`, `req_trigger`.
  - **PEND:** `req_valid=1`, payload held stable until `req_valid & req_ready`, then → HOLD. `debug_mode` rising does not withdraw the request.
  - **HOLD:** fixed 2 cycles covering the pipeline-flush shadow, then → IDLE.
- **Reset (asserted at any time, including mid-PEND):** state IDLE, `q`=0, `hit`=0, `req_valid`=0, `req_action`/`req_slot`/`req_trigger`=0, `busy`=0. A pending request is dropped.

## Timing
- Match presented in cycle N is captured at the end of N.
- `req_valid` and `hit` update at the end of N+1, so they are visible in N+2. Latency is 2 cycles.
- `req_ready` high in the first PEND cycle gives a handshake in that cycle; HOLD occupies the next 2 cycles. The earliest next capture is in the cycle after HOLD.
- `req_ready` is ignored outside PEND.
- `hit_clr` takes effect in 1 cycle.
- `busy` is registered and equals (state ≠ IDLE).

## Configuration
- **`TRIG_HIT_COUNTER_EN` defined:**
  - Adds output `hit_count` [num_triggers][7:0].
  - Each entry is an 8-bit saturating counter (stops at 255), incremented in every cycle the corresponding `hit` bit is set by a fire.
  - Cleared by `hit_clr` and by reset; increment wins over clear in the same cycle.
- **Undefined:** the port and the counters are absent; all other behaviour is identical.

## Test plan
- **Single trigger:** trigger 1 enabled, `match_in[1][2]=1`, `slot_valid=4'b0100` in cycle 0 → `req_valid` in cycle 2, `req_slot=2`, `req_trigger=1`, `hit=4'b0010`.
- **Chain:**
  - `trig_chain=4'b0011` (group 0..2); `q` sets 0 and 1 only in slot 0 → no request.
  - Add trigger 2 in slot 0 → request with `req_trigger=0` and `hit=4'b0111`.
- **Priority:**
  - Trigger 0 (action 0) in slot 3 and trigger 3 (action 1) in slot 1 → `req_slot=1`, `req_action=1`, `hit=4'b1000`.
  - Trigger 1 (action 0) and trigger 2 (action 1) both in slot 1 → `req_trigger=1`, `req_action=1`.
- **Backpressure:** `req_ready=0` for 5 cycles → payload stable and new matches ignored; `req_ready=1` → 2 HOLD cycles, then IDLE.
- **Suppression and edges:**
  - `debug_mode=1` with matches → nothing happens.
  - `hit_clr[0]` coincident with a trigger-0 hit → `hit[0]` stays 1.
  - Reset deasserted→asserted mid-PEND → `req_valid=0` immediately.
- **Counter (`TRIG_HIT_COUNTER_EN`):** 300 trigger-2 fires → `hit_count[2]=255`; `hit_clr[2]` → 0.

Source files
------------

// File: rtl/trigger_hit_sequencer.sv
// rtl/trigger_hit_sequencer.sv - debug-trigger hit qualification, sticky hit status and action request
//
// Purpose:
//   Registers the comparator match matrix after enable, slot-valid and
//   debug-mode qualification. Resolves chain groups and picks the oldest
//   firing slot. Sets sticky hit bits and issues one prioritised action
//   request to the core, then holds off for a 2-cycle flush shadow.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   match_i        [trigger][slot] comparator match matrix
//   slot_valid_i   per-slot committing-instruction valid (slot 0 oldest)
//   trig_enable_i  per-trigger arm
//   trig_chain_i   trigger i chains to i+1 (top bit ignored)
//   trig_action_i  0 = breakpoint exception, 1 = enter debug mode
//   debug_mode_i   core in debug mode, suppresses all triggers
//   hit_clr_i      per-trigger sticky hit clear
//   req_valid_o    action request pending
//   req_ready_i    core accepts the request
//   req_action_o   action of the request
//   req_slot_o     slot that fired
//   req_trigger_o  first trigger of the firing chain group
//   hit_o          sticky hit bits
//   busy_o         sequencer not idle (registered)
//   hit_count_o    per-trigger 8-bit saturating fire counters
//                  (present only when TRIG_HIT_COUNTER_EN is defined)
module trigger_hit_sequencer #(
  parameter int  NUM_TRIGGERS = 4,
  parameter int  NUM_SLOTS    = 4,
  localparam int SLOT_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int TRIG_W       = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NUM_TRIGGERS-1:0][NUM_SLOTS-1:0] match_i,
  input  logic [NUM_SLOTS-1:0]                   slot_valid_i,
  input  logic [NUM_TRIGGERS-1:0]                trig_enable_i,
  input  logic [NUM_TRIGGERS-1:0]                trig_chain_i,
  input  logic [NUM_TRIGGERS-1:0]                trig_action_i,
  input  logic                                   debug_mode_i,
  input  logic [NUM_TRIGGERS-1:0]                hit_clr_i,
  output logic                                   req_valid_o,
  input  logic                                   req_ready_i,
  output logic                                   req_action_o,
  output logic [SLOT_W-1:0]                      req_slot_o,
  output logic [TRIG_W-1:0]                      req_trigger_o,
  output logic [NUM_TRIGGERS-1:0]                hit_o,
  output logic                                   busy_o
`ifdef TRIG_HIT_COUNTER_EN
  ,
  output logic [NUM_TRIGGERS-1:0][7:0]           hit_count_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_HOLD1, S_HOLD2} state_e;

  state_e                                 state_q, state_d;
  logic [NUM_TRIGGERS-1:0][NUM_SLOTS-1:0] q_q, q_d;
  logic [NUM_TRIGGERS-1:0]                hit_q, hit_d;
  logic                                   req_action_q, req_action_d;
  logic [SLOT_W-1:0]                      req_slot_q, req_slot_d;
  logic [TRIG_W-1:0]                      req_trigger_q, req_trigger_d;
  logic                                   busy_q, busy_d;

  logic [NUM_TRIGGERS-1:0]                chain_eff;
  logic [NUM_TRIGGERS-1:0]                group_start;
  logic [NUM_TRIGGERS-1:0][NUM_SLOTS-1:0] grp_fire;
  logic [NUM_SLOTS-1:0]                   slot_fire;
  logic [NUM_TRIGGERS-1:0]                sel_groups;
  logic [NUM_TRIGGERS-1:0]                sel_members;
  logic [SLOT_W-1:0]                      sel_slot;
  logic [TRIG_W-1:0]                      sel_trig;
  logic                                   sel_action;
  logic                                   fire;
  logic                                   unused_chain_msb;

  // The last trigger has no successor, so its chain bit is forced low.
  assign chain_eff        = {1'b0, trig_chain_i[NUM_TRIGGERS-2:0]};
  assign unused_chain_msb = trig_chain_i[NUM_TRIGGERS-1];
  // A trigger starts a group when its predecessor does not chain into it.
  assign group_start      = ~{chain_eff[NUM_TRIGGERS-2:0], 1'b0};

  // Group detection: walking down from the top trigger, 'tail' is set when
  // trigger i and every later member of its group are set in slot j.
  always_comb begin
    logic tail;
    tail      = 1'b1;
    grp_fire  = '0;
    slot_fire = '0;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      tail = 1'b1;
      for (int i = NUM_TRIGGERS - 1; i >= 0; i--) begin
        tail           = q_q[i][j] & (~chain_eff[i] | tail);
        grp_fire[i][j] = group_start[i] & tail;
        slot_fire[j]   = slot_fire[j] | grp_fire[i][j];
      end
    end
  end

  // Oldest firing slot wins; within it the lowest group start is reported,
  // and the action is debug-entry if any fired group ends on a debug trigger.
  always_comb begin
    sel_slot    = '0;
    sel_groups  = '0;
    sel_trig    = '0;
    sel_members = '0;
    for (int j = NUM_SLOTS - 1; j >= 0; j--) begin
      if (slot_fire[j]) begin
        sel_slot = SLOT_W'(j);
        for (int i = 0; i < NUM_TRIGGERS; i++) begin
          sel_groups[i] = grp_fire[i][j];
        end
      end
    end
    for (int i = NUM_TRIGGERS - 1; i >= 0; i--) begin
      if (sel_groups[i]) begin
        sel_trig = TRIG_W'(i);
      end
    end
    // Spread each fired start across the rest of its group.
    sel_members[0] = sel_groups[0];
    for (int i = 1; i < NUM_TRIGGERS; i++) begin
      sel_members[i] = sel_groups[i] | (chain_eff[i-1] & sel_members[i-1]);
    end
    sel_action = |(sel_members & ~chain_eff & trig_action_i);
    fire       = (state_q == S_IDLE) && (|slot_fire);
  end

  // Stage 1 only captures while idle and not firing, so matches arriving
  // during a pending request or its flush shadow are discarded.
  always_comb begin
    q_d = '0;
    if ((state_q == S_IDLE) && !fire && !debug_mode_i) begin
      for (int i = 0; i < NUM_TRIGGERS; i++) begin
        for (int j = 0; j < NUM_SLOTS; j++) begin
          q_d[i][j] = match_i[i][j] & slot_valid_i[j] & trig_enable_i[i];
        end
      end
    end
  end

  // Set wins over a coincident clear.
  assign hit_d = (hit_q & ~hit_clr_i) | (fire ? sel_members : '0);

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fire) state_d = S_PEND;
      S_PEND:  if (req_ready_i) state_d = S_HOLD1;
      S_HOLD1: state_d = S_HOLD2;
      S_HOLD2: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and payload capture.
  always_comb begin
    req_valid_o   = (state_q == S_PEND);
    req_action_d  = fire ? sel_action : req_action_q;
    req_slot_d    = fire ? sel_slot   : req_slot_q;
    req_trigger_d = fire ? sel_trig   : req_trigger_q;
    busy_d        = (state_d != S_IDLE);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      q_q           <= '0;
      hit_q         <= '0;
      req_action_q  <= 1'b0;
      req_slot_q    <= '0;
      req_trigger_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      q_q           <= q_d;
      hit_q         <= hit_d;
      req_action_q  <= req_action_d;
      req_slot_q    <= req_slot_d;
      req_trigger_q <= req_trigger_d;
      busy_q        <= busy_d;
    end
  end

  assign req_action_o  = req_action_q;
  assign req_slot_o    = req_slot_q;
  assign req_trigger_o = req_trigger_q;
  assign hit_o         = hit_q;
  assign busy_o        = busy_q;

`ifdef TRIG_HIT_COUNTER_EN
  logic [NUM_TRIGGERS-1:0][7:0] cnt_q, cnt_d;

  // Increment takes precedence over clear; the count sticks at 255.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      if (fire && sel_members[i]) begin
        if (cnt_q[i] != 8'hFF) begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end else if (hit_clr_i[i]) begin
        cnt_d[i] = 8'd0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_count_o = cnt_q;
`else
  // Hit counters are not built; only the sticky hit bits are kept.
`endif

endmodule

// File: tb/tb_trigger_hit_sequencer.sv
// tb/tb_trigger_hit_sequencer.sv - scoreboard bench for trigger_hit_sequencer
module tb_trigger_hit_sequencer;

  typedef struct packed {
    logic       act;
    logic [1:0] slot;
    logic [1:0] trig;
    logic [3:0] hit;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [3:0][3:0] match;
  logic [3:0]      slot_valid;
  logic [3:0]      trig_enable;
  logic [3:0]      trig_chain;
  logic [3:0]      trig_action;
  logic            debug_mode;
  logic [3:0]      hit_clr;
  logic            req_valid;
  logic            req_ready;
  logic            req_action;
  logic [1:0]      req_slot;
  logic [1:0]      req_trigger;
  logic [3:0]      hit;
  logic            busy;
`ifdef TRIG_HIT_COUNTER_EN
  logic [3:0][7:0] hit_count;
`endif

  int   total;
  int   bad;
  int   hs_count;
  exp_t exp_q[$];

  trigger_hit_sequencer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .match_i       (match),
    .slot_valid_i  (slot_valid),
    .trig_enable_i (trig_enable),
    .trig_chain_i  (trig_chain),
    .trig_action_i (trig_action),
    .debug_mode_i  (debug_mode),
    .hit_clr_i     (hit_clr),
    .req_valid_o   (req_valid),
    .req_ready_i   (req_ready),
    .req_action_o  (req_action),
    .req_slot_o    (req_slot),
    .req_trigger_o (req_trigger),
    .hit_o         (hit),
    .busy_o        (busy)
`ifdef TRIG_HIT_COUNTER_EN
    ,
    .hit_count_o   (hit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0][3:0] m, input logic [3:0] sv);
    match      = m;
    slot_valid = sv;
    tick();
    match      = '0;
    slot_valid = '0;
  endtask

  task automatic settle(input string name);
    int n;
    n = 0;
    repeat (2) tick();
    while ((busy || req_valid) && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(busy | req_valid), 32'd0);
  endtask

  task automatic clear_hits(input string name);
    hit_clr = 4'hF;
    tick();
    hit_clr = 4'h0;
    check(name, 32'(hit), 32'd0);
  endtask

  // Monitor: checks payload stability while pending and pops the scoreboard
  // on every accepted request.
  initial begin
    logic [4:0] held;
    logic       in_pend;
    exp_t       e;
    in_pend = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_pend = 1'b0;
      end else if (req_valid) begin
        if (in_pend) begin
          check("payload_stable", 32'({req_action, req_slot, req_trigger}), 32'(held));
        end else begin
          held    = {req_action, req_slot, req_trigger};
          in_pend = 1'b1;
        end
        if (req_ready) begin
          hs_count++;
          in_pend = 1'b0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_req: got slot=%0d trig=%0d want none", req_slot, req_trigger);
          end else begin
            e = exp_q.pop_front();
            check("req_action",  32'(req_action),  32'(e.act));
            check("req_slot",    32'(req_slot),    32'(e.slot));
            check("req_trigger", 32'(req_trigger), 32'(e.trig));
            check("hit",         32'(hit),         32'(e.hit));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0][3:0] m;
    total       = 0;
    bad         = 0;
    hs_count    = 0;
    rst_n       = 1'b0;
    match       = '0;
    slot_valid  = '0;
    trig_enable = '0;
    trig_chain  = '0;
    trig_action = 4'b1100;
    debug_mode  = 1'b0;
    hit_clr     = '0;
    req_ready   = 1'b1;
    repeat (2) tick();
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_hit",       32'(hit),       32'd0);
    rst_n = 1'b1;
    tick();

    // Single trigger, latency and HOLD length.
    trig_enable = 4'b0010;
    m = '0; m[1][2] = 1'b1;
    exp_q.push_back('{act: 1'b0, slot: 2'd2, trig: 2'd1, hit: 4'b0010});
    present(m, 4'b0100);
    check("lat_c1_valid", 32'(req_valid), 32'd0);
    tick();
    check("lat_c2_valid", 32'(req_valid), 32'd1);
    check("lat_c2_busy",  32'(busy),      32'd1);
    tick();
    check("hold1_valid",  32'(req_valid), 32'd0);
    check("hold1_busy",   32'(busy),      32'd1);
    tick();
    check("hold2_busy",   32'(busy),      32'd1);
    tick();
    check("idle_busy",    32'(busy),      32'd0);
    clear_hits("clr_single");

    // Chain group 0..2: incomplete then complete.
    trig_chain  = 4'b0011;
    trig_enable = 4'b0111;
    m = '0; m[0][0] = 1'b1; m[1][0] = 1'b1;
    present(m, 4'b0001);
    settle("chain_partial_idle");
    check("chain_partial_hit", 32'(hit), 32'd0);
    m[2][0] = 1'b1;
    exp_q.push_back('{act: 1'b1, slot: 2'd0, trig: 2'd0, hit: 4'b0111});
    present(m, 4'b0001);
    settle("chain_full_idle");
    trig_chain = 4'b0000;
    clear_hits("clr_chain");

    // Oldest slot wins.
    trig_enable = 4'b1001;
    m = '0; m[0][3] = 1'b1; m[3][1] = 1'b1;
    exp_q.push_back('{act: 1'b1, slot: 2'd1, trig: 2'd3, hit: 4'b1000});
    present(m, 4'b1111);
    settle("prio_slot_idle");
    clear_hits("clr_prio_slot");

    // Two groups in one slot: lowest trigger reported, debug action wins.
    trig_enable = 4'b0110;
    m = '0; m[1][1] = 1'b1; m[2][1] = 1'b1;
    exp_q.push_back('{act: 1'b1, slot: 2'd1, trig: 2'd1, hit: 4'b0110});
    present(m, 4'b1111);
    settle("prio_trig_idle");
    clear_hits("clr_prio_trig");

    // Backpressure: 5 stalled cycles with fresh matches that must be ignored.
    trig_enable = 4'b1001;
    req_ready   = 1'b0;
    m = '0; m[0][0] = 1'b1;
    exp_q.push_back('{act: 1'b0, slot: 2'd0, trig: 2'd0, hit: 4'b0001});
    present(m, 4'b0001);
    tick();
    check("bp_valid", 32'(req_valid), 32'd1);
    m = '0; m[3][0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      match      = m;
      slot_valid = 4'b0001;
      tick();
    end
    match      = '0;
    slot_valid = '0;
    req_ready  = 1'b1;
    tick();
    check("bp_hold1_busy",  32'(busy),      32'd1);
    check("bp_hold1_valid", 32'(req_valid), 32'd0);
    tick();
    check("bp_hold2_busy",  32'(busy),      32'd1);
    tick();
    check("bp_idle_busy",   32'(busy),      32'd0);
    repeat (3) tick();
    check("bp_no_second",   32'(req_valid), 32'd0);
    check("bp_hit",         32'(hit),       32'd1);
    clear_hits("clr_bp");

    // Debug mode suppresses everything.
    debug_mode  = 1'b1;
    trig_enable = 4'b1111;
    m = '1;
    present(m, 4'b1111);
    repeat (3) tick();
    check("dbg_valid", 32'(req_valid), 32'd0);
    check("dbg_busy",  32'(busy),      32'd0);
    check("dbg_hit",   32'(hit),       32'd0);
    debug_mode = 1'b0;

    // Set wins over coincident clear; plain clear acts in one cycle.
    trig_enable = 4'b0001;
    m = '0; m[0][0] = 1'b1;
    exp_q.push_back('{act: 1'b0, slot: 2'd0, trig: 2'd0, hit: 4'b0001});
    present(m, 4'b0001);
    settle("setclr_first_idle");
    exp_q.push_back('{act: 1'b0, slot: 2'd0, trig: 2'd0, hit: 4'b0001});
    present(m, 4'b0001);
    hit_clr = 4'b0001;
    tick();
    hit_clr = 4'b0000;
    check("set_wins_hit", 32'(hit), 32'd1);
    settle("setclr_second_idle");
    hit_clr = 4'b0001;
    tick();
    hit_clr = 4'b0000;
    check("clr_one_cycle", 32'(hit), 32'd0);

    // Reset asserted while a request is pending.
    req_ready = 1'b0;
    present(m, 4'b0001);
    tick();
    check("rstmid_valid_before", 32'(req_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", 32'(req_valid), 32'd0);
    check("rstmid_busy",  32'(busy),      32'd0);
    check("rstmid_hit",   32'(hit),       32'd0);
    tick();
    rst_n     = 1'b1;
    req_ready = 1'b1;
    repeat (3) tick();
    check("rstmid_no_req", 32'(req_valid), 32'd0);

`ifdef TRIG_HIT_COUNTER_EN
    begin
      int base;
      int n;
      trig_enable = 4'b0100;
      for (int k = 0; k < 300; k++) begin
        exp_q.push_back('{act: 1'b1, slot: 2'd0, trig: 2'd2, hit: 4'b0100});
      end
      base = hs_count;
      n    = 0;
      m = '0; m[2][0] = 1'b1;
      match      = m;
      slot_valid = 4'b0001;
      while ((hs_count - base) < 300 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("cnt_fires", 32'(hs_count - base), 32'd300);
      tick();
      match      = '0;
      slot_valid = '0;
      settle("cnt_idle");
      check("cnt_sat",   32'(hit_count[2]), 32'd255);
      check("cnt_other", 32'(hit_count[0]), 32'd0);
      hit_clr = 4'b0100;
      tick();
      hit_clr = 4'b0000;
      check("cnt_clr", 32'(hit_count[2]), 32'd0);
    end
`endif

    repeat (2) tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
